axi_rd_master: RTL and testbench
================================

Name: axi_rd_master

Overview:
- PL-side read master: converts a simple single-request read interface into an AXI3 read address (AR) and read data (R) channel on a 64-bit HP port.
- It is the read counterpart of the existing axi0 write path. PL blocks (DMA readers, waveform players) fetch DDR bursts through it.
- One transaction is outstanding at a time.
- Sits beside the PS wrapper; runs on the axi0 clock domain.

Parameters:
- AXI_DW, 64, data width in bits (fixed 64; arsize derived as 3'b011)
- AXI_AW, 32, address width
- AXI_IW, 6, ID width
- AXI_ID, 0, constant ARID issued and expected on RID
- LEN_W, 4, burst length field width (beats-1, max 16 beats)

Ports:
- axi_clk_i  in  1  clock
- axi_rstn_i  in  1  reset, synchronous, active-low
- rd_addr_i  in  AXI_AW  start byte address
- rd_len_i  in  LEN_W  beats-1
- rd_fixed_i  in  1  1 = FIXED burst, 0 = INCR
- rd_req_i  in  1  request strobe, sampled only when rd_busy_o=0
- rd_busy_o  out  1  transaction in progress
- rd_data_o  out  AXI_DW  returned beat
- rd_dvalid_o  out  1  rd_data_o valid (one cycle per beat)
- rd_last_o  out  1  transaction end marker
- rd_err_o  out  1  error summary, valid with rd_last_o
- arid_o, araddr_o, arlen_o, arsize_o, arburst_o  out  AXI_IW/AXI_AW/4/3/2  AR fields
- arlock_o 2, arcache_o 4, arprot_o 3, arqos_o 4  out  constants 0, 4'b0011, 0, 0
- arvalid_o  out 1; arready_i  in 1
- rid_i  in AXI_IW; rdata_i  in AXI_DW; rresp_i  in 2; rlast_i  in 1; rvalid_i  in 1; rready_o  out 1

Behaviour:
- Reset (axi_rstn_i=0 at a clock edge): state IDLE; every output 0 except constant AR fields; the error flag and beat counter are cleared.
  - Reset mid-transaction abandons the transaction with no rd_last_o. The PS is reset together with the PL.
- FSM states: IDLE, ADDR, DATA, DRAIN, DONE.
- IDLE: rd_busy_o=0. rd_req_i=1 → capture addr, len and fixed, set rd_busy_o=1 next cycle.
  - araddr_o = rd_addr_i with bits [2:0] forced 0; misalignment sets the error flag.
  - 4KB check: INCR with addr[11:0] + (len+1)*8 > 4096 → no AR is issued; go to DONE (rd_last_o=1, rd_err_o=1 two cycles after the request).
  - Otherwise go to ADDR: arvalid_o=1 in cycle N+1 for a request in cycle N.
- ADDR: hold arvalid_o and all AR fields stable until arready_i=1, then go to DATA with arvalid_o=0 in the next cycle.
- DATA: rready_o=1 continuously; the client cannot backpressure.
  - Each R handshake registers rdata_i → rd_data_o with rd_dvalid_o=1 one cycle later (1-cycle latency). The beat counter increments.
  - The error flag is set if rresp_i[1]=1 or rid_i != AXI_ID.
  - rlast_i=1 on the handshake: rd_last_o=1 with that beat. If the count != len+1 (early RLAST), set rd_err_o. Go to DONE.
  - Count reaches len+1 without rlast_i: go to DRAIN.
- DRAIN: rready_o=1; extra beats are discarded (rd_dvalid_o=0). On rlast_i, go to DONE and emit rd_last_o=1, rd_dvalid_o=0, rd_err_o=1.
- DONE: one cycle, then IDLE; rd_busy_o falls the cycle after rd_last_o. A new request may be accepted the cycle rd_busy_o=0.
- rd_err_o is valid only when rd_last_o=1; it is 0 otherwise.
- arburst_o = 2'b00 if fixed, else 2'b01. arlen_o = {0, rd_len_i}.
- Beat counter width is LEN_W+1 so that 16 beats does not wrap.
- rd_req_i while busy is ignored (no queueing).

Decomposition:
- Shared package holds:
  - AXI burst/resp constants (BURST_FIXED/INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR)
  - ARCACHE default
  - FSM state encoding
  - the 4KB page size constant
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Aligned INCR, addr 0x0010_0000, len 3, ARREADY after 2 cycles, RVALID back-to-back → araddr 0x0010_0000, arlen 3, arburst 01; 4 dvalid pulses with data matching, rd_last on the 4th, rd_err=0, busy low 1 cycle later.
- RRESP=2'b10 on beat 2 of a 4-beat burst → all 4 beats delivered, rd_err=1 with rd_last.
- Early RLAST on beat 2 of len 3 → 2 dvalid beats, rd_last on beat 2, rd_err=1, FSM returns to IDLE.
- Late RLAST: slave returns 6 beats for len 3 → 4 dvalid beats, 2 discarded, then rd_last alone with rd_err=1.
- 4KB crossing, addr 0x0000_0FF0, len 3 INCR → no arvalid, rd_last=rd_err=1 two cycles after the request; same address with fixed=1 → issued normally.
- Reset asserted in DATA after beat 1 → next cycle arvalid=rready=busy=dvalid=0; a new request is then accepted normally.

Source files
------------

// File: rtl/axi_rd_master_pkg.sv
// Shared AXI3 constants and FSM encoding for the PL-side read master.
package axi_rd_master_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [3:0] ARCACHE_DEF = 4'b0011;
   localparam logic [2:0] ARSIZE_8B   = 3'b011;

   localparam int unsigned PAGE_BYTES = 4096;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // True when an INCR burst of 8-byte beats runs past the 4KB page end.
   function automatic logic crosses_page(
      input logic [11:0] off,
      input logic [4:0]  beats
   );
      logic [13:0] end_b;
      end_b = {2'b00, off} + {6'b0, beats, 3'b000};
      return end_b > 14'(PAGE_BYTES);
   endfunction

endpackage

// File: rtl/axi_rd_master_if.sv
// AXI3 read address and read data channels seen from the master side.
interface axi_rd_master_if #(
   parameter int AW = 32,
   parameter int IW = 6,
   parameter int DW = 64
);

   logic [IW-1:0] arid_o;
   logic [AW-1:0] araddr_o;
   logic [3:0]    arlen_o;
   logic [2:0]    arsize_o;
   logic [1:0]    arburst_o;
   logic [1:0]    arlock_o;
   logic [3:0]    arcache_o;
   logic [2:0]    arprot_o;
   logic [3:0]    arqos_o;
   logic          arvalid_o;
   logic          arready_i;

   logic [IW-1:0] rid_i;
   logic [DW-1:0] rdata_i;
   logic [1:0]    rresp_i;
   logic          rlast_i;
   logic          rvalid_i;
   logic          rready_o;

   modport master (
      output arid_o, araddr_o, arlen_o, arsize_o, arburst_o,
      output arlock_o, arcache_o, arprot_o, arqos_o, arvalid_o,
      input  arready_i,
      input  rid_i, rdata_i, rresp_i, rlast_i, rvalid_i,
      output rready_o
   );

   modport slave (
      input  arid_o, araddr_o, arlen_o, arsize_o, arburst_o,
      input  arlock_o, arcache_o, arprot_o, arqos_o, arvalid_o,
      output arready_i,
      output rid_i, rdata_i, rresp_i, rlast_i, rvalid_i,
      input  rready_o
   );

endinterface

// File: rtl/axi_rd_master.sv
// Single-outstanding AXI3 read master: one request in, one burst out,
// beats returned with 1-cycle latency and an error summary on the last.
module axi_rd_master
   import axi_rd_master_pkg::*;
#(
   parameter int AXI_DW = 64,
   parameter int AXI_AW = 32,
   parameter int AXI_IW = 6,
   parameter int AXI_ID = 0,
   parameter int LEN_W  = 4
) (
   input  logic              axi_clk_i,
   input  logic              axi_rstn_i,
   input  logic [AXI_AW-1:0] rd_addr_i,
   input  logic [LEN_W-1:0]  rd_len_i,
   input  logic              rd_fixed_i,
   input  logic              rd_req_i,
   output logic              rd_busy_o,
   output logic [AXI_DW-1:0] rd_data_o,
   output logic              rd_dvalid_o,
   output logic              rd_last_o,
   output logic              rd_err_o,
   axi_rd_master_if.master   axi
);

   localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

   state_e              state_q, state_d;
   logic [AXI_AW-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [1:0]          burst_q, burst_d;
   logic                cross_q, cross_d;
   logic                err_q, err_d;
   logic [LEN_W:0]      cnt_q, cnt_d;
   logic [AXI_DW-1:0]   data_q, data_d;
   logic                dvalid_q, dvalid_d;
   logic                last_q, last_d;
   logic                rerr_q, rerr_d;

   logic [LEN_W:0]      beats;
   logic [LEN_W:0]      cnt_nx;
   logic [LEN_W:0]      req_beats;
   logic                resp_bad;
   logic                id_bad;
   logic                err_nx;

   always_ff @(posedge axi_clk_i) begin
      if (!axi_rstn_i) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         burst_q  <= '0;
         cross_q  <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         data_q   <= '0;
         dvalid_q <= 1'b0;
         last_q   <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         burst_q  <= burst_d;
         cross_q  <= cross_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         dvalid_q <= dvalid_d;
         last_q   <= last_d;
         rerr_q   <= rerr_d;
      end
   end

   always_comb begin
      resp_bad = 1'b0;
      unique case (axi.rresp_i)
         RESP_OKAY,
         RESP_EXOKAY: resp_bad = 1'b0;
         RESP_SLVERR,
         RESP_DECERR: resp_bad = 1'b1;
         default:     resp_bad = 1'b1;
      endcase
   end

   assign id_bad    = axi.rid_i != AXI_IW'(AXI_ID);
   assign beats     = {1'b0, len_q} + CNT_ONE;
   assign req_beats = {1'b0, rd_len_i} + CNT_ONE;
   assign cnt_nx    = cnt_q + CNT_ONE;
   assign err_nx    = err_q | resp_bad | id_bad;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      burst_d  = burst_q;
      cross_d  = cross_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      dvalid_d = 1'b0;
      last_d   = 1'b0;
      rerr_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (rd_req_i) begin
               addr_d  = {rd_addr_i[AXI_AW-1:3], 3'b000};
               len_d   = rd_len_i;
               burst_d = rd_fixed_i ? BURST_FIXED : BURST_INCR;
               cross_d = !rd_fixed_i &&
                         crosses_page(rd_addr_i[11:0], 5'(req_beats));
               err_d   = |rd_addr_i[2:0];
               cnt_d   = '0;
               state_d = ST_ADDR;
            end
         end
         // A page-crossing burst spends its ADDR cycle silent, then reports.
         ST_ADDR: begin
            if (cross_q) begin
               last_d  = 1'b1;
               rerr_d  = 1'b1;
               state_d = ST_DONE;
            end else if (axi.arready_i) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (axi.rvalid_i) begin
               data_d   = axi.rdata_i;
               dvalid_d = 1'b1;
               cnt_d    = cnt_nx;
               err_d    = err_nx;
               if (axi.rlast_i) begin
                  last_d  = 1'b1;
                  rerr_d  = err_nx | (cnt_nx != beats);
                  state_d = ST_DONE;
               end else if (cnt_nx == beats) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         // Surplus beats are swallowed; the overrun is reported at RLAST.
         ST_DRAIN: begin
            if (axi.rvalid_i && axi.rlast_i) begin
               last_d  = 1'b1;
               rerr_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign rd_busy_o   = state_q != ST_IDLE;
   assign rd_data_o   = data_q;
   assign rd_dvalid_o = dvalid_q;
   assign rd_last_o   = last_q;
   assign rd_err_o    = rerr_q;

   assign axi.arid_o    = AXI_IW'(AXI_ID);
   assign axi.araddr_o  = addr_q;
   assign axi.arlen_o   = 4'(len_q);
   assign axi.arsize_o  = ARSIZE_8B;
   assign axi.arburst_o = burst_q;
   assign axi.arlock_o  = 2'b00;
   assign axi.arcache_o = ARCACHE_DEF;
   assign axi.arprot_o  = 3'b000;
   assign axi.arqos_o   = 4'b0000;
   assign axi.arvalid_o = (state_q == ST_ADDR) && !cross_q;
   assign axi.rready_o  = (state_q == ST_DATA) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_axi_rd_master.sv
// Bench for axi_rd_master: table of bursts plus hand-written corner
// sequences, returned beats scored against a queue of expected data.
module tb_axi_rd_master;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] rd_addr;
   logic [3:0]  rd_len;
   logic        rd_fixed;
   logic        rd_req;
   logic        rd_busy;
   logic [63:0] rd_data;
   logic        rd_dvalid;
   logic        rd_last;
   logic        rd_err;

   axi_rd_master_if #(.AW(32), .IW(6), .DW(64)) bus ();

   axi_rd_master dut (
      .axi_clk_i   (clk),
      .axi_rstn_i  (rstn),
      .rd_addr_i   (rd_addr),
      .rd_len_i    (rd_len),
      .rd_fixed_i  (rd_fixed),
      .rd_req_i    (rd_req),
      .rd_busy_o   (rd_busy),
      .rd_data_o   (rd_data),
      .rd_dvalid_o (rd_dvalid),
      .rd_last_o   (rd_last),
      .rd_err_o    (rd_err),
      .axi         (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  len;
      logic        fixed;
      int          ar_wait;
      int          nbeats;
      int          bad_resp;
      int          bad_id;
      logic [31:0] exp_araddr;
      logic        exp_err;
      logic        exp_ldv;
   } vec_t;

   vec_t        vt[9];
   logic [63:0] q[$];
   int          checks   = 0;
   int          failures = 0;
   logic        exp_err;
   logic        exp_ldv;
   logic        last_seen;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%b exp=%b", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic mon();
      logic [63:0] e;
      if (rd_dvalid) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat act=%h exp=none", rd_data);
         end else begin
            e = q.pop_front();
            chkw("rdata", rd_data, e);
         end
      end
      if (rd_last) begin
         last_seen = 1'b1;
         chk1("rd_err", rd_err, exp_err);
         chk1("last_dvalid", rd_dvalid, exp_ldv);
      end else if (rd_err) begin
         chk1("err_no_last", rd_err, 1'b0);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      mon();
   endtask

   task automatic request(input logic [31:0] a, input logic [3:0] l,
                          input logic f);
      rd_addr  = a;
      rd_len   = l;
      rd_fixed = f;
      rd_req   = 1'b1;
      last_seen = 1'b0;
      cyc();
      rd_req   = 1'b0;
   endtask

   task automatic run_txn(input vec_t v);
      logic [63:0] d;
      exp_err = v.exp_err;
      exp_ldv = v.exp_ldv;
      request(v.addr, v.len, v.fixed);
      chk1("arvalid_lat", bus.arvalid_o, 1'b1);
      chkw("araddr", 64'(bus.araddr_o), 64'(v.exp_araddr));
      chkw("arlen", 64'(bus.arlen_o), 64'(v.len));
      chkw("arburst", 64'(bus.arburst_o), v.fixed ? 64'(0) : 64'(1));
      for (int w = 0; w < v.ar_wait; w++) begin
         cyc();
         chk1("arvalid_hold", bus.arvalid_o, 1'b1);
         chkw("araddr_hold", 64'(bus.araddr_o), 64'(v.exp_araddr));
      end
      bus.arready_i = 1'b1;
      cyc();
      bus.arready_i = 1'b0;
      chk1("arvalid_drop", bus.arvalid_o, 1'b0);
      for (int b = 0; b < v.nbeats; b++) begin
         chk1("rready", bus.rready_o, 1'b1);
         d = {$urandom, $urandom};
         bus.rvalid_i = 1'b1;
         bus.rdata_i  = d;
         bus.rlast_i  = (b == v.nbeats - 1);
         bus.rresp_i  = (b == v.bad_resp) ? 2'b10 : 2'b00;
         bus.rid_i    = (b == v.bad_id) ? 6'd5 : 6'd0;
         if (b <= int'(v.len)) q.push_back(d);
         cyc();
      end
      bus.rvalid_i = 1'b0;
      bus.rlast_i  = 1'b0;
      bus.rresp_i  = 2'b00;
      bus.rid_i    = 6'd0;
      for (int i = 0; i < 8; i++) begin
         if (last_seen) break;
         cyc();
      end
      chk1("last_seen", last_seen, 1'b1);
      cyc();
      chk1("busy_fall", rd_busy, 1'b0);
      chkw("q_empty", 64'(q.size()), 64'(0));
      q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{32'h0010_0000, 4'd3,  1'b0, 2, 4,  -1, -1,
                32'h0010_0000, 1'b0, 1'b1};
      vt[1] = '{32'h0010_0100, 4'd3,  1'b0, 0, 4,   1, -1,
                32'h0010_0100, 1'b1, 1'b1};
      vt[2] = '{32'h0010_0200, 4'd3,  1'b0, 1, 2,  -1, -1,
                32'h0010_0200, 1'b1, 1'b1};
      vt[3] = '{32'h0010_0300, 4'd3,  1'b0, 0, 6,  -1, -1,
                32'h0010_0300, 1'b1, 1'b0};
      vt[4] = '{32'h0000_0FF0, 4'd3,  1'b1, 0, 4,  -1, -1,
                32'h0000_0FF0, 1'b0, 1'b1};
      vt[5] = '{32'h0020_0004, 4'd1,  1'b0, 0, 2,  -1, -1,
                32'h0020_0000, 1'b1, 1'b1};
      vt[6] = '{32'h0030_0000, 4'd15, 1'b0, 3, 16, -1, -1,
                32'h0030_0000, 1'b0, 1'b1};
      vt[7] = '{32'h0030_1000, 4'd0,  1'b0, 0, 1,  -1,  0,
                32'h0030_1000, 1'b1, 1'b1};
      vt[8] = '{32'h0000_0FF0, 4'd1,  1'b0, 0, 2,  -1, -1,
                32'h0000_0FF0, 1'b0, 1'b1};

      rstn          = 1'b0;
      rd_addr       = '0;
      rd_len        = '0;
      rd_fixed      = 1'b0;
      rd_req        = 1'b0;
      exp_err       = 1'b0;
      exp_ldv       = 1'b0;
      last_seen     = 1'b0;
      bus.arready_i = 1'b0;
      bus.rvalid_i  = 1'b0;
      bus.rlast_i   = 1'b0;
      bus.rresp_i   = 2'b00;
      bus.rid_i     = 6'd0;
      bus.rdata_i   = '0;
      cyc();
      cyc();
      chk1("rst_busy", rd_busy, 1'b0);
      chk1("rst_arvalid", bus.arvalid_o, 1'b0);
      chk1("rst_rready", bus.rready_o, 1'b0);
      chk1("rst_dvalid", rd_dvalid, 1'b0);
      chk1("rst_last", rd_last, 1'b0);
      chkw("rst_data", rd_data, 64'(0));
      chkw("rst_araddr", 64'(bus.araddr_o), 64'(0));
      chkw("rst_arburst", 64'(bus.arburst_o), 64'(0));
      chkw("arid", 64'(bus.arid_o), 64'(0));
      chkw("arsize", 64'(bus.arsize_o), 64'(3));
      chkw("arcache", 64'(bus.arcache_o), 64'(3));
      chkw("arlock", 64'(bus.arlock_o), 64'(0));
      chkw("arprot", 64'(bus.arprot_o), 64'(0));
      chkw("arqos", 64'(bus.arqos_o), 64'(0));
      rstn = 1'b1;
      cyc();

      for (int i = 0; i < 9; i++) run_txn(vt[i]);

      // 4KB crossing: no AR, last+err two cycles after the request
      exp_err = 1'b1;
      exp_ldv = 1'b0;
      request(32'h0000_0FF0, 4'd3, 1'b0);
      chk1("x_arvalid0", bus.arvalid_o, 1'b0);
      chk1("x_busy", rd_busy, 1'b1);
      chk1("x_nolast", rd_last, 1'b0);
      cyc();
      chk1("x_arvalid1", bus.arvalid_o, 1'b0);
      chk1("x_last", rd_last, 1'b1);
      cyc();
      chk1("x_busy_fall", rd_busy, 1'b0);
      chk1("x_last_clr", rd_last, 1'b0);

      // reset in DATA after the first beat abandons the burst
      exp_err = 1'b0;
      exp_ldv = 1'b1;
      request(32'h0040_0000, 4'd3, 1'b0);
      bus.arready_i = 1'b1;
      cyc();
      bus.arready_i = 1'b0;
      bus.rvalid_i  = 1'b1;
      bus.rdata_i   = 64'hDEAD_BEEF_0123_4567;
      q.push_back(64'hDEAD_BEEF_0123_4567);
      cyc();
      bus.rvalid_i = 1'b0;
      chkw("r_q_empty", 64'(q.size()), 64'(0));
      rstn = 1'b0;
      cyc();
      chk1("r_arvalid", bus.arvalid_o, 1'b0);
      chk1("r_rready", bus.rready_o, 1'b0);
      chk1("r_busy", rd_busy, 1'b0);
      chk1("r_dvalid", rd_dvalid, 1'b0);
      chk1("r_last", rd_last, 1'b0);
      rstn = 1'b1;
      run_txn(vt[0]);

      // request while busy is ignored
      exp_err = 1'b0;
      exp_ldv = 1'b1;
      request(32'h0050_0000, 4'd0, 1'b0);
      rd_req  = 1'b1;
      rd_addr = 32'h0060_0000;
      cyc();
      rd_req  = 1'b0;
      chkw("busy_req_addr", 64'(bus.araddr_o), 64'(32'h0050_0000));
      bus.arready_i = 1'b1;
      cyc();
      bus.arready_i = 1'b0;
      bus.rvalid_i  = 1'b1;
      bus.rlast_i   = 1'b1;
      bus.rdata_i   = 64'h1111_2222_3333_4444;
      q.push_back(64'h1111_2222_3333_4444);
      cyc();
      bus.rvalid_i = 1'b0;
      bus.rlast_i  = 1'b0;
      chk1("b_last", last_seen, 1'b1);
      cyc();
      chk1("b_idle", rd_busy, 1'b0);
      cyc();
      chk1("b_no_requeue", rd_busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
